// File: rtl/prog_loader.sv
// Packs (Q, Q1) nibble pairs into program bytes and writes them to RAM at consecutive addresses from a loaded base.
// A handshake in ACCEPT gives a write one cycle later, so the loader takes one byte per 2 cycles; in_valid is ignored outside ACCEPT.
module prog_loader #(
   parameter int AW = 12,
   parameter int NW = 4
) (
   input  logic            CLK,
   input  logic            R,
   input  logic            start,
   input  logic [AW-1:0]   base,
   input  logic [AW:0]     len,
   input  logic            in_valid,
   input  logic [NW-1:0]   Q,
   input  logic [NW-1:0]   Q1,
   output logic            in_ready,
   output logic            we,
   output logic [AW-1:0]   waddr,
   output logic [2*NW-1:0] wdata,
   output logic            busy,
   output logic            done,
   output logic            wrapped
);

   typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

   state_t        state;
   logic [AW-1:0] addr;
   logic [AW:0]   rem;

   // Inverse of the fetch split: Q supplies the odd bits, Q1 the even bits.
   function automatic logic [2*NW-1:0] pack(input logic [NW-1:0] odd, input logic [NW-1:0] even);
      pack = '0;
      for (int i = 0; i < NW; i++) begin
         pack[2*i+1] = odd[i];
         pack[2*i]   = even[i];
      end
   endfunction

   always_ff @(posedge CLK) begin
      if (R) begin
         state   <= IDLE;
         addr    <= '0;
         rem     <= '0;
         we      <= 1'b0;
         waddr   <= '0;
         wdata   <= '0;
         wrapped <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr    <= base;
                  rem     <= len;
                  wrapped <= 1'b0;
                  state   <= (len != '0) ? ACCEPT : DONE;
               end
            end
            ACCEPT: begin
               if (in_valid) begin
                  waddr <= addr;
                  wdata <= pack(Q, Q1);
                  we    <= 1'b1;
                  state <= WRITE;
               end
            end
            WRITE: begin
               we   <= 1'b0;
               addr <= addr + 1'b1;
               rem  <= rem - 1'b1;
               if (addr == '1)
                  wrapped <= 1'b1;
               state <= (rem == {{AW{1'b0}}, 1'b1}) ? DONE : ACCEPT;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Pure decodes of the state register; they change only on a clock edge.
   assign in_ready = (state == ACCEPT);
   assign busy     = (state == ACCEPT) || (state == WRITE);
   assign done     = (state == DONE);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
   localparam int AW = 12;
   localparam int NW = 4;

   logic            CLK = 1'b0;
   logic            R = 1'b1;
   logic            start = 1'b0;
   logic [AW-1:0]   base = '0;
   logic [AW:0]     len = '0;
   logic            in_valid = 1'b0;
   logic [NW-1:0]   Q = '0;
   logic [NW-1:0]   Q1 = '0;
   logic            in_ready, we, busy, done, wrapped;
   logic [AW-1:0]   waddr;
   logic [2*NW-1:0] wdata;

   int n_cmp = 0;
   int n_bad = 0;
   logic [AW+2*NW-1:0] exp_q[$];

   prog_loader #(.AW(AW), .NW(NW)) dut (
      .CLK(CLK), .R(R), .start(start), .base(base), .len(len),
      .in_valid(in_valid), .Q(Q), .Q1(Q1), .in_ready(in_ready), .we(we),
      .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .wrapped(wrapped)
   );

   always #5 CLK = ~CLK;

   // Scoreboard: every observed write must match the oldest expected one.
   always @(negedge CLK) begin
      if (we === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got addr=%h data=%h, required no write", waddr, wdata);
         end else begin
            logic [AW+2*NW-1:0] e;
            e = exp_q.pop_front();
            if ({waddr, wdata} !== e) begin
               n_bad++;
               $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                        waddr, wdata, e[AW+2*NW-1:2*NW], e[2*NW-1:0]);
            end
         end
      end
   end

   logic [AW-1:0] exp_addr;

   function automatic logic [7:0] ref_pack(input logic [3:0] q, input logic [3:0] q1);
      ref_pack = {q[3], q1[3], q[2], q1[2], q[1], q1[1], q[0], q1[0]};
   endfunction

   task automatic start_run(input logic [AW-1:0] b, input logic [AW:0] l);
      start = 1'b1; base = b; len = l;
      exp_addr = b;
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   // Present a pair; returns 1 time unit after the accepting edge.
   task automatic send(input logic [3:0] q, input logic [3:0] q1, input logic [7:0] exp_d, input bit hold);
      bit ok;
      ok = 0;
      in_valid = 1'b1; Q = q; Q1 = q1;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge CLK);
         if (in_ready === 1'b1) begin
            exp_q.push_back({exp_addr, exp_d});
            exp_addr = exp_addr + 1'b1;
            ok = 1;
         end
         @(posedge CLK); #1;
      end
      if (!hold) in_valid = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL handshake_timeout: got in_ready=%b, required 1 within 50 cycles", in_ready);
      end
   endtask

   task automatic test_reset;
      R = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      n_cmp++;
      if ({in_ready, we, busy, done, wrapped, waddr, wdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got rdy=%b we=%b busy=%b done=%b wrap=%b addr=%h data=%h, required all 0",
                  in_ready, we, busy, done, wrapped, waddr, wdata);
      end
      @(posedge CLK); #1;
      R = 1'b0;
   endtask

   task automatic test_single;
      start_run(12'h010, 1);
      @(negedge CLK);
      n_cmp++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         n_bad++; $display("FAIL ready_after_start: got rdy=%b busy=%b, required 1 1", in_ready, busy);
      end
      @(posedge CLK); #1;
      send(4'b1010, 4'b0101, 8'h99, 0);
      @(negedge CLK);
      n_cmp++;
      if (we !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
         n_bad++; $display("FAIL single_we_cycle: got we=%b done=%b rdy=%b, required 1 0 0", we, done, in_ready);
      end
      @(negedge CLK);
      n_cmp++;
      if (done !== 1'b1 || we !== 1'b0) begin
         n_bad++; $display("FAIL single_done: got done=%b we=%b, required 1 0", done, we);
      end
      @(negedge CLK);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL single_done_pulse: got done=%b busy=%b, required 0 0", done, busy);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_burst;
      start_run(12'h000, 3);
      send(4'hF, 4'h0, 8'hAA, 1);
      send(4'h0, 4'hF, 8'h55, 1);
      send(4'h5, 4'hA, 8'h66, 1);
      in_valid = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++; $display("FAIL burst_done: got done=%b, required 1", done);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_wrap;
      start_run(12'hFFE, 4);
      send(4'h1, 4'h2, ref_pack(4'h1, 4'h2), 0);
      send(4'h3, 4'h4, ref_pack(4'h3, 4'h4), 0);
      @(negedge CLK);
      n_cmp++;
      if (wrapped !== 1'b0) begin
         n_bad++; $display("FAIL wrap_early: got wrapped=%b, required 0", wrapped);
      end
      @(negedge CLK);
      n_cmp++;
      if (wrapped !== 1'b1) begin
         n_bad++; $display("FAIL wrap_set: got wrapped=%b, required 1", wrapped);
      end
      @(posedge CLK); #1;
      send(4'h5, 4'h6, ref_pack(4'h5, 4'h6), 0);
      send(4'h7, 4'h8, ref_pack(4'h7, 4'h8), 0);
      repeat (4) @(negedge CLK);
      n_cmp++;
      if (wrapped !== 1'b1 || busy !== 1'b0) begin
         n_bad++; $display("FAIL wrap_hold_idle: got wrapped=%b busy=%b, required 1 0", wrapped, busy);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_len_zero_and_start;
      start_run(12'h123, 0);
      @(negedge CLK);
      n_cmp++;
      if (done !== 1'b1 || in_ready !== 1'b0 || wrapped !== 1'b0) begin
         n_bad++; $display("FAIL len0_done: got done=%b rdy=%b wrap=%b, required 1 0 0", done, in_ready, wrapped);
      end
      @(negedge CLK);
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++; $display("FAIL len0_pulse: got done=%b, required 0", done);
      end
      @(posedge CLK); #1;
      start_run(12'h200, 3);
      start = 1'b1; base = 12'h700; len = 1;
      send(4'h9, 4'h1, ref_pack(4'h9, 4'h1), 0);
      send(4'h2, 4'hC, ref_pack(4'h2, 4'hC), 0);
      send(4'hE, 4'h7, ref_pack(4'hE, 4'h7), 0);
      start = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++; $display("FAIL midstart_done: got done=%b, required 1", done);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_stall;
      start_run(12'h055, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         n_cmp++;
         if (in_ready !== 1'b1 || busy !== 1'b1 || we !== 1'b0) begin
            n_bad++; $display("FAIL stall_%0d: got rdy=%b busy=%b we=%b, required 1 1 0", i, in_ready, busy, we);
         end
      end
      @(posedge CLK); #1;
      send(4'hB, 4'h3, ref_pack(4'hB, 4'h3), 0);
      repeat (3) @(posedge CLK); #1;
   endtask

   task automatic test_reset_midrun;
      start_run(12'hFFF, 3);
      send(4'h1, 4'h1, ref_pack(4'h1, 4'h1), 0);
      @(negedge CLK);
      @(negedge CLK);
      n_cmp++;
      if (wrapped !== 1'b1 || in_ready !== 1'b1) begin
         n_bad++; $display("FAIL pre_reset: got wrap=%b rdy=%b, required 1 1", wrapped, in_ready);
      end
      R = 1'b1;
      repeat (2) @(posedge CLK);
      #1 R = 1'b0;
      in_valid = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if ({in_ready, we, busy, wrapped, done} !== 5'b0) begin
         n_bad++; $display("FAIL reset_accept: got rdy=%b we=%b busy=%b wrap=%b done=%b, required 0", in_ready, we, busy, wrapped, done);
      end
      repeat (5) @(posedge CLK);
      #1 in_valid = 1'b0;
      start_run(12'h300, 3);
      send(4'h2, 4'h3, ref_pack(4'h2, 4'h3), 1);
      R = 1'b1;
      @(posedge CLK); #1;
      R = 1'b0;
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      n_cmp++;
      if (busy !== 1'b0 || we !== 1'b0 || in_ready !== 1'b0) begin
         n_bad++; $display("FAIL reset_write: got busy=%b we=%b rdy=%b, required 0 0 0", busy, we, in_ready);
      end
      @(posedge CLK); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_wrap();
      test_len_zero_and_start();
      test_stall();
      test_reset_midrun();
      repeat (2) @(posedge CLK);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL missing_writes: got %0d pending, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish before 200000");
      $fatal(1);
   end
endmodule
